instr_encoder_loader: RTL and testbench

//  Encoder counterpart of the opcode decoder. Accepts decoded instruction fields (class, regs, funct, imm)

---
 rtl/instr_encoder_loader.sv | 216 +++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//    Boot/test loader front end. Takes decoded instruction fields over a
//    valid/ready handshake and packs each bundle into an RV32I instruction
//    word. Each word is written into instruction memory at an incrementing
//    word address. A session starts with a start pulse. It ends on an END
//    bundle, when memory is full, or when an illegal class arrives.
//
// Ports:
//    clk        in   1         clock, rising edge
//    rstN       in   1         asynchronous active-low reset
//    start      in   1         pulse: begin a new load session at address 0
//    in_valid   in   1         field bundle valid
//    in_ready   out  1         encoder can accept a bundle (RUN only)
//    in_class   in   4         instruction class (15 = END, 9..14 illegal)
//    in_rd      in   5         destination register
//    in_rs1     in   5         source register 1
//    in_rs2     in   5         source register 2
//    in_funct3  in   3         funct3 field
//    in_f7b5    in   1         instruction bit 30
//    in_imm     in   32        immediate in value form
//    mem_we     out  1         imem write strobe (one cycle per word)
//    mem_addr   out  ADDR_W    imem word address
//    mem_wdata  out  32        encoded instruction
//    busy       out  1         session active (RUN or WRITE)
//    done       out  1         session ended cleanly
//    error      out  1         session aborted on an illegal class
//    count      out  ADDR_W+1  words written this session
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_class,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_f7b5,
   input  logic [31:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   count
);

   localparam logic [3:0] CLS_LTYPE = 4'd0;
   localparam logic [3:0] CLS_ITYPE = 4'd1;
   localparam logic [3:0] CLS_AUIPC = 4'd2;
   localparam logic [3:0] CLS_STYPE = 4'd3;
   localparam logic [3:0] CLS_RTYPE = 4'd4;
   localparam logic [3:0] CLS_LUI   = 4'd5;
   localparam logic [3:0] CLS_BTYPE = 4'd6;
   localparam logic [3:0] CLS_JALR  = 4'd7;
   localparam logic [3:0] CLS_JTYPE = 4'd8;
   localparam logic [3:0] CLS_END   = 4'd15;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      WRITE,
      DONE,
      ERR
   } stateT;

   stateT             r_state;
   stateT             w_nextState;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic [31:0]       r_wdata;
   logic [31:0]       w_encoded;
   logic              w_accept;
   logic              w_legal;
   logic              w_isShiftImm;

   // A bundle transfers only while RUN presents in_ready. Classes 0..8 are
   // the only ones that produce a memory word; END and illegal classes
   // change state without writing anything.
   assign w_accept     = (r_state == RUN) && in_valid;
   assign w_legal      = (in_class <= CLS_JTYPE);
   assign w_isShiftImm = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

   // Field packer. Immediates arrive in value form, so B and J types drop
   // imm[0] and scatter the remaining bits into their RISC-V positions.
   // Shift-immediates carry only a 5-bit shamt, with f7b5 selecting
   // arithmetic versus logical shifts.
   always_comb begin
      w_encoded = 32'h0000_0000;
      case (in_class)
         CLS_LTYPE: w_encoded = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
         CLS_ITYPE: begin
            if (w_isShiftImm) begin
               w_encoded = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IMM};
            end else begin
               w_encoded = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
            end
         end
         CLS_JALR:  w_encoded = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
         CLS_STYPE: w_encoded = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
         CLS_RTYPE: w_encoded = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_REG};
         CLS_LUI:   w_encoded = {in_imm[31:12], in_rd, OP_LUI};
         CLS_AUIPC: w_encoded = {in_imm[31:12], in_rd, OP_AUIPC};
         CLS_BTYPE: w_encoded = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], OP_BRANCH};
         CLS_JTYPE: w_encoded = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
         default:   w_encoded = 32'h0000_0000;
      endcase
   end

   // State register. Because the reset is asynchronous, an abort in the
   // middle of WRITE drops mem_we immediately.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. start is honoured only from the idle-like states
   // (IDLE, DONE, ERR), so a running session cannot be restarted midway.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start) w_nextState = RUN;
         end
         RUN: begin
            if (w_accept) begin
               if (in_class == CLS_END) begin
                  w_nextState = DONE;
               end else if (w_legal) begin
                  w_nextState = WRITE;
               end else begin
                  w_nextState = ERR;
               end
            end
         end
         WRITE: begin
            if (r_addr == LAST_ADDR) begin
               w_nextState = DONE;
            end else begin
               w_nextState = RUN;
            end
         end
         DONE, ERR: begin
            if (start) w_nextState = RUN;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath. The encoded word is latched on acceptance and held through
   // WRITE. The address advances as WRITE retires. On the last memory slot
   // the address is held so mem_addr still shows the final word written.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_addr  <= '0;
         r_count <= '0;
         r_wdata <= 32'h0000_0000;
      end else begin
         case (r_state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  r_addr  <= '0;
                  r_count <= '0;
               end
            end
            RUN: begin
               if (w_accept && w_legal) r_wdata <= w_encoded;
            end
            WRITE: begin
               r_count <= r_count + (ADDR_W + 1)'(1);
               if (r_addr != LAST_ADDR) r_addr <= r_addr + ADDR_W'(1);
            end
            default: begin
               r_addr <= r_addr;
            end
         endcase
      end
   end

   // Status outputs decode straight from the state, so they follow an
   // asynchronous reset without waiting for a clock.
   assign in_ready  = (r_state == RUN);
   assign mem_we    = (r_state == WRITE);
   assign busy      = (r_state == RUN) || (r_state == WRITE);
   assign done      = (r_state == DONE);
   assign error     = (r_state == ERR);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Testbench for instr_encoder_loader, built with a four-word memory so the
// full-memory ending is reachable. The stimulus process pushes each expected
// memory write {addr, data} into a queue. A monitor pops that queue on every
// mem_we pulse and compares the result.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rstN;
   logic              start;
   logic              inValid;
   logic              inReady;
   logic [3:0]        inClass;
   logic [4:0]        inRd;
   logic [4:0]        inRs1;
   logic [4:0]        inRs2;
   logic [2:0]        inFunct3;
   logic              inF7b5;
   logic [31:0]       inImm;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [31:0]       memWdata;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   count;

   instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rstN      (rstN),
      .start     (start),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_class  (inClass),
      .in_rd     (inRd),
      .in_rs1    (inRs1),
      .in_rs2    (inRs2),
      .in_funct3 (inFunct3),
      .in_f7b5   (inF7b5),
      .in_imm    (inImm),
      .mem_we    (memWe),
      .mem_addr  (memAddr),
      .mem_wdata (memWdata),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .count     (count)
   );

   // 10-time-unit clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic        f7b5;
      logic [31:0] imm;
      logic [31:0] exp;
   } vecT;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } expT;

   vecT               vecs [12];
   expT               sbQ [$];
   logic [ADDR_W-1:0] expAddr;
   int                vectorsApplied = 0;
   int                miscompares    = 0;

   // Shared compare helper. Every comparison in the bench goes through
   // this task so the summary counts stay accurate.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorsApplied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Scoreboard monitor. Every write strobe must match the oldest expected
   // entry. A strobe with nothing queued counts as a spurious write.
   always @(negedge clk) begin
      expT e;
      if (memWe === 1'b1) begin
         if (sbQ.size() == 0) begin
            vectorsApplied++;
            miscompares++;
            $display("[TB] FAIL unexpectedWrite: got write addr %0d data 0x%08h, expected no write",
                     memAddr, memWdata);
         end else begin
            e = sbQ.pop_front();
            checkOutput("writeAddr", 32'(memAddr), 32'(e.addr));
            checkOutput("writeData", memWdata, e.data);
         end
      end
   end

   task automatic driveFields(input vecT v);
      inClass  = v.cls;
      inRd     = v.rd;
      inRs1    = v.rs1;
      inRs2    = v.rs2;
      inFunct3 = v.f3;
      inF7b5   = v.f7b5;
      inImm    = v.imm;
   endtask

   // Present one bundle and wait, up to the given budget, for in_ready.
   // The expected write is queued only for legal classes that are accepted.
   // Called and returns at posedge+1.
   task automatic applyStimulus(input vecT v, input bit holdValid, input int budget, output bit accepted);
      driveFields(v);
      inValid  = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (inReady === 1'b1) begin
            accepted = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (accepted) begin
         if (v.cls <= 4'd8) begin
            sbQ.push_back('{expAddr, v.exp});
            expAddr = expAddr + 8'd1;
         end
         @(posedge clk);
         #1;
      end
      if (!holdValid) inValid = 1'b0;
   endtask

   task automatic sendWord(input int idx);
      bit acc;
      applyStimulus(vecs[idx], 1'b0, 10, acc);
      checkOutput($sformatf("accepted[%0d]", idx), 32'(acc), 32'd1);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      expAddr = '0;
   endtask

   // Safety net so the bench can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit acc;
      // Directed vectors with hand-encoded expected words. Fields that an
      // encoding ignores are filled with junk on purpose.
      vecs[0]  = '{4'd1,  5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_0005, 32'h0050_0093}; // addi x1,x0,5
      vecs[1]  = '{4'd4,  5'd3,  5'd1, 5'd2, 3'd0, 1'b1, 32'h0000_0000, 32'h4020_81B3}; // sub x3,x1,x2
      vecs[2]  = '{4'd6,  5'd31, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'hFE20_8EE3}; // beq x1,x2,-4
      vecs[3]  = '{4'd8,  5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_0800, 32'h0010_00EF}; // jal x1,0x800
      vecs[4]  = '{4'd5,  5'd5,  5'd9, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 32'h1234_52B7}; // lui x5
      vecs[5]  = '{4'd3,  5'd0,  5'd1, 5'd2, 3'd2, 1'b0, 32'h0000_0008, 32'h0020_A423}; // sw x2,8(x1)
      vecs[6]  = '{4'd0,  5'd5,  5'd2, 5'd0, 3'd2, 1'b0, 32'h0000_0004, 32'h0041_2283}; // lw x5,4(x2)
      vecs[7]  = '{4'd1,  5'd6,  5'd7, 5'd0, 3'd5, 1'b1, 32'h0000_0FE3, 32'h4033_D313}; // srai x6,x7,3
      vecs[8]  = '{4'd7,  5'd1,  5'd5, 5'd0, 3'd7, 1'b0, 32'h0000_0010, 32'h0102_80E7}; // jalr x1,16(x5)
      vecs[9]  = '{4'd2,  5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E123, 32'hABCD_E517}; // auipc x10
      vecs[10] = '{4'd15, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 32'h0000_0000, 32'h0000_0000}; // END
      vecs[11] = '{4'd10, 5'd1,  5'd1, 5'd1, 3'd0, 1'b0, 32'h0000_0000, 32'h0000_0000}; // illegal

      rstN    = 1'b1;
      start   = 1'b0;
      inValid = 1'b0;
      expAddr = '0;
      driveFields(vecs[0]);
      #2 rstN = 1'b0;
      #1;
      checkOutput("rstInReady", 32'(inReady),  32'd0);
      checkOutput("rstMemWe",   32'(memWe),    32'd0);
      checkOutput("rstBusy",    32'(busy),     32'd0);
      checkOutput("rstDone",    32'(done),     32'd0);
      checkOutput("rstError",   32'(error),    32'd0);
      checkOutput("rstAddr",    32'(memAddr),  32'd0);
      checkOutput("rstWdata",   memWdata,      32'd0);
      checkOutput("rstCount",   32'(count),    32'd0);
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;

      // IDLE ignores bundles until start.
      inValid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idleInReady", 32'(inReady), 32'd0);
      checkOutput("idleBusy",    32'(busy),    32'd0);
      inValid = 1'b0;

      // Session 1: three words, then END.
      $display("[TB] session 1: addi/sub/beq then END");
      pulseStart();
      checkOutput("s1RunReady", 32'(inReady), 32'd1);
      checkOutput("s1RunBusy",  32'(busy),    32'd1);
      sendWord(0);
      sendWord(1);
      sendWord(2);
      sendWord(10);
      checkOutput("s1Done",    32'(done),    32'd1);
      checkOutput("s1Busy",    32'(busy),    32'd0);
      checkOutput("s1Count",   32'(count),   32'd3);
      checkOutput("s1InReady", 32'(inReady), 32'd0);

      // Session 2: two words, then an illegal class aborts.
      $display("[TB] session 2: sw/lw then illegal class");
      pulseStart();
      checkOutput("s2DoneCleared", 32'(done),    32'd0);
      checkOutput("s2CountClear",  32'(count),   32'd0);
      checkOutput("s2AddrClear",   32'(memAddr), 32'd0);
      sendWord(5);
      sendWord(6);
      sendWord(11);
      checkOutput("s2Error", 32'(error), 32'd1);
      checkOutput("s2Done",  32'(done),  32'd0);
      checkOutput("s2Count", 32'(count), 32'd2);
      checkOutput("s2Busy",  32'(busy),  32'd0);
      pulseStart();
      checkOutput("s2ErrCleared", 32'(error),   32'd0);
      checkOutput("s2RestartAddr", 32'(memAddr), 32'd0);
      checkOutput("s2RestartCnt",  32'(count),   32'd0);
      checkOutput("s2RestartRdy",  32'(inReady), 32'd1);

      // Session 3: valid held high, six words offered into four slots.
      $display("[TB] session 3: streaming into a full memory");
      applyStimulus(vecs[3], 1'b1, 10, acc);
      checkOutput("s3Acc0", 32'(acc), 32'd1);
      applyStimulus(vecs[4], 1'b1, 10, acc);
      checkOutput("s3Acc1", 32'(acc), 32'd1);
      applyStimulus(vecs[7], 1'b1, 10, acc);
      checkOutput("s3Acc2", 32'(acc), 32'd1);
      applyStimulus(vecs[8], 1'b1, 10, acc);
      checkOutput("s3Acc3", 32'(acc), 32'd1);
      applyStimulus(vecs[9], 1'b1, 4, acc);
      checkOutput("s3Reject4", 32'(acc), 32'd0);
      applyStimulus(vecs[1], 1'b1, 3, acc);
      checkOutput("s3Reject5", 32'(acc), 32'd0);
      inValid = 1'b0;
      checkOutput("s3Done",    32'(done),    32'd1);
      checkOutput("s3InReady", 32'(inReady), 32'd0);
      checkOutput("s3Count",   32'(count),   32'd4);
      checkOutput("s3AddrHeld", 32'(memAddr), 32'd3);

      // Session 4: reset asserted while the write strobe is high.
      $display("[TB] session 4: reset during WRITE");
      pulseStart();
      driveFields(vecs[0]);
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checkOutput("s4InWrite", 32'(memWe), 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("s4RstMemWe", 32'(memWe),   32'd0);
      checkOutput("s4RstBusy",  32'(busy),    32'd0);
      checkOutput("s4RstAddr",  32'(memAddr), 32'd0);
      checkOutput("s4RstWdata", memWdata,     32'd0);
      checkOutput("s4RstCount", 32'(count),   32'd0);
      checkOutput("s4RstReady", 32'(inReady), 32'd0);
      @(posedge clk);
      #1 rstN = 1'b1;
      driveFields(vecs[4]);
      inValid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("s4NoStartReady", 32'(inReady), 32'd0);
      checkOutput("s4NoStartBusy",  32'(busy),    32'd0);
      inValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
